// File: rtl/mapper_trap_sched_pkg.sv
// -----------------------------------------------------------------------------
// mapper_trap_sched_pkg
// Shared definitions for the mapper trap scheduler: FSM state encoding,
// Z80 vector/opcode constants and the trap cause-code width.
// -----------------------------------------------------------------------------
package mapper_trap_sched_pkg;

    localparam int CAUSE_W = 4;

    localparam logic [15:0] NMI_VECTOR = 16'h0066;
    localparam logic [7:0]  OP_ED      = 8'hED;
    localparam logic [7:0]  OP_RETN    = 8'h45;

    typedef enum logic [2:0] {
        ST_USER  = 3'd0,
        ST_ARMED = 3'd1,
        ST_NMI   = 3'd2,
        ST_SUPER = 3'd3,
        ST_EXIT  = 3'd4
    } state_e;

endpackage

// File: rtl/mapper_trap_sched_if.sv
// -----------------------------------------------------------------------------
// mapper_trap_sched_if
// Raw Z80 bus signals watched by the mapper.
//   m1_n, mreq_n, rd_n : active-low CPU strobes (asynchronous to clk)
//   addr               : 16-bit address bus
//   data               : 8-bit data bus
// Modports: master (the CPU side drives the bus), slave (bus watchers).
// -----------------------------------------------------------------------------
interface mapper_trap_sched_if;
    logic        m1_n;
    logic        mreq_n;
    logic        rd_n;
    logic [15:0] addr;
    logic [7:0]  data;

    modport master (output m1_n, output mreq_n, output rd_n, output addr, output data);
    modport slave  (input  m1_n, input  mreq_n, input  rd_n, input  addr, input  data);
endinterface

// File: rtl/mapper_trap_sched_z80_bus_sync.sv
// -----------------------------------------------------------------------------
// z80_bus_sync
// Synchronises the Z80 M1/MREQ/RD strobes into clk (2 flops each), produces a
// one-clock pulse on each synchronised rising edge of M1, and latches the
// opcode and address of the current opcode fetch.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : raw Z80 bus (slave modport)
//   m1_rise      : 1-clock pulse at the end of every opcode fetch
//   opcode       : last byte read while M1/MREQ/RD were all low
//   fetch_addr   : address captured alongside opcode
// -----------------------------------------------------------------------------
module z80_bus_sync (
    input  logic                clk,
    input  logic                reset_n,
    mapper_trap_sched_if.slave  bus,
    output logic                m1_rise,
    output logic [7:0]          opcode,
    output logic [15:0]         fetch_addr
);
    logic [1:0]  m1_sync_q;
    logic [1:0]  mreq_sync_q;
    logic [1:0]  rd_sync_q;
    logic        m1_prev_q;
    logic [7:0]  opcode_q;
    logic [15:0] fetch_addr_q;
    logic        fetch_active;

    assign fetch_active = ~m1_sync_q[1] & ~mreq_sync_q[1] & ~rd_sync_q[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: strobes reset to their idle-high level so leaving reset
            // cannot fabricate an M1 rising edge.
            m1_sync_q    <= 2'b11;
            mreq_sync_q  <= 2'b11;
            rd_sync_q    <= 2'b11;
            m1_prev_q    <= 1'b1;
            opcode_q     <= '0;
            fetch_addr_q <= '0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge value of its source, which is what a sync chain needs.
            m1_sync_q   <= {m1_sync_q[0], bus.m1_n};
            mreq_sync_q <= {mreq_sync_q[0], bus.mreq_n};
            rd_sync_q   <= {rd_sync_q[0], bus.rd_n};
            m1_prev_q   <= m1_sync_q[1];
            if (fetch_active) begin
                opcode_q     <= bus.data;
                fetch_addr_q <= bus.addr;
            end
        end
    end

    assign m1_rise    = m1_sync_q[1] & ~m1_prev_q;
    assign opcode     = opcode_q;
    assign fetch_addr = fetch_addr_q;
endmodule

// File: rtl/mapper_trap_sched.sv
// -----------------------------------------------------------------------------
// mapper_trap_sched
// Sequences the mapper between user mode (mapping on) and supervisor mode
// (mapping off). A trap is latched, deferred to the next real instruction
// boundary, signalled with NMI, confirmed by the 0x0066 vector fetch, and
// undone EXIT_FETCHES opcode fetches after RETN.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : raw Z80 bus (slave modport)
//   at_isr_end   : instruction-boundary flag, valid at synchronised M1 rise
//   trap_req     : one-clock trap pulse, trap_cause valid with it
//   nmi_n        : NMI to CPU, active low
//   map_en       : 1 = user mapping active
//   trap_busy    : registered (state != USER)
//   cause_q      : cause of the trap in progress
//   ack_err      : sticky vector-ack timeout flag
// Optional feature: define MAPPER_ACK_TIMEOUT_EN to abandon an NMI that is not
// acknowledged within ACK_TIMEOUT clocks; otherwise NMI retries forever and
// ack_err is tied low.
// -----------------------------------------------------------------------------
module mapper_trap_sched
    import mapper_trap_sched_pkg::*;
#(
    parameter int NMI_HOLD     = 16,
    parameter int EXIT_FETCHES = 1,
    parameter int ACK_TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                reset_n,
    mapper_trap_sched_if.slave  bus,
    input  logic                at_isr_end,
    input  logic                trap_req,
    input  logic [CAUSE_W-1:0]  trap_cause,
    output logic                nmi_n,
    output logic                map_en,
    output logic                trap_busy,
    output logic [CAUSE_W-1:0]  cause_q,
    output logic                ack_err
);
    // Zero exit fetches would let mapping return mid-RETN; clamp to one.
    localparam int EXIT_N  = (EXIT_FETCHES < 1) ? 1 : EXIT_FETCHES;
    localparam int EXIT_W  = $clog2(EXIT_N + 1);
    // One width serves both the NMI hold counter and the ack timeout counter.
    localparam int CNT_MAX = (NMI_HOLD > ACK_TIMEOUT) ? NMI_HOLD : ACK_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(NMI_HOLD - 1);

    logic        m1_rise;
    logic [7:0]  opcode;
    logic [15:0] fetch_addr;
    logic        vector_fetch;

    state_e               state_q, state_d;
    logic                 nmi_n_q, nmi_n_d;
    logic                 map_en_q, map_en_d;
    logic                 trap_busy_q, trap_busy_d;
    logic [CAUSE_W-1:0]   cause_lat_q, cause_lat_d;
    logic [CNT_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic [EXIT_W-1:0]    exit_cnt_q, exit_cnt_d;
    logic                 ed_seen_q, ed_seen_d;
`ifdef MAPPER_ACK_TIMEOUT_EN
    localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);
    logic [CNT_W-1:0]     ack_cnt_q, ack_cnt_d;
    logic                 ack_err_q, ack_err_d;
`endif

    z80_bus_sync u_bus_sync (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .m1_rise    (m1_rise),
        .opcode     (opcode),
        .fetch_addr (fetch_addr)
    );

    assign vector_fetch = m1_rise && (fetch_addr == NMI_VECTOR);

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        state_d     = state_q;
        nmi_n_d     = nmi_n_q;
        map_en_d    = map_en_q;
        cause_lat_d = cause_lat_q;
        hold_cnt_d  = hold_cnt_q;
        exit_cnt_d  = exit_cnt_q;
        ed_seen_d   = ed_seen_q;
`ifdef MAPPER_ACK_TIMEOUT_EN
        ack_cnt_d   = ack_cnt_q;
        ack_err_d   = ack_err_q;
`endif
        case (state_q)
            ST_USER: begin
                nmi_n_d  = 1'b1;
                map_en_d = 1'b1;
                if (trap_req) begin
                    state_d     = ST_ARMED;
                    cause_lat_d = trap_cause;
                end
            end
            ST_ARMED: begin
                // A fetch that is not a boundary is a prefix byte; keep waiting.
                if (m1_rise && at_isr_end) begin
                    state_d    = ST_NMI;
                    nmi_n_d    = 1'b0;
                    hold_cnt_d = '0;
`ifdef MAPPER_ACK_TIMEOUT_EN
                    ack_cnt_d  = '0;
`endif
                end
            end
            ST_NMI: begin
`ifdef MAPPER_ACK_TIMEOUT_EN
                ack_cnt_d = ack_cnt_q + CNT_W'(1);
`endif
                if (vector_fetch) begin
                    state_d   = ST_SUPER;
                    nmi_n_d   = 1'b1;
                    map_en_d  = 1'b0;
                    ed_seen_d = 1'b0;
`ifdef MAPPER_ACK_TIMEOUT_EN
                end else if (ack_cnt_q == ACK_LAST) begin
                    state_d   = ST_USER;
                    nmi_n_d   = 1'b1;
                    map_en_d  = 1'b1;
                    ack_err_d = 1'b1;
`endif
                end else if (nmi_n_q) begin
                    // One-clock release is over; reassert and restart the hold.
                    nmi_n_d    = 1'b0;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    nmi_n_d    = 1'b1;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            ST_SUPER: begin
                map_en_d = 1'b0;
                if (m1_rise) begin
                    if (ed_seen_q && (opcode == OP_RETN)) begin
                        state_d    = ST_EXIT;
                        exit_cnt_d = EXIT_W'(EXIT_N);
                        ed_seen_d  = 1'b0;
                    end else begin
                        ed_seen_d = (opcode == OP_ED);
                    end
                end
            end
            ST_EXIT: begin
                map_en_d = 1'b0;
                if (m1_rise) begin
                    if (exit_cnt_q <= EXIT_W'(1)) begin
                        state_d    = ST_USER;
                        map_en_d   = 1'b1;
                        exit_cnt_d = '0;
                    end else begin
                        exit_cnt_d = exit_cnt_q - EXIT_W'(1);
                    end
                end
            end
            default: begin
                state_d  = ST_USER;
                nmi_n_d  = 1'b1;
                map_en_d = 1'b1;
            end
        endcase
        // Registered from the next state so it lines up with map_en.
        trap_busy_d = (state_d != ST_USER);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_USER;
            nmi_n_q     <= 1'b1;
            map_en_q    <= 1'b1;
            trap_busy_q <= 1'b0;
            cause_lat_q <= '0;
            hold_cnt_q  <= '0;
            exit_cnt_q  <= '0;
            ed_seen_q   <= 1'b0;
`ifdef MAPPER_ACK_TIMEOUT_EN
            ack_cnt_q   <= '0;
            ack_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            nmi_n_q     <= nmi_n_d;
            map_en_q    <= map_en_d;
            trap_busy_q <= trap_busy_d;
            cause_lat_q <= cause_lat_d;
            hold_cnt_q  <= hold_cnt_d;
            exit_cnt_q  <= exit_cnt_d;
            ed_seen_q   <= ed_seen_d;
`ifdef MAPPER_ACK_TIMEOUT_EN
            ack_cnt_q   <= ack_cnt_d;
            ack_err_q   <= ack_err_d;
`endif
        end
    end

    assign nmi_n     = nmi_n_q;
    assign map_en    = map_en_q;
    assign trap_busy = trap_busy_q;
    assign cause_q   = cause_lat_q;
`ifdef MAPPER_ACK_TIMEOUT_EN
    assign ack_err   = ack_err_q;
`else
    assign ack_err   = 1'b0;
`endif
endmodule

// File: tb/tb_mapper_trap_sched.sv
// -----------------------------------------------------------------------------
// tb_mapper_trap_sched
// Directed bench for mapper_trap_sched: trap/boundary deferral, vector ack,
// RETN exit, NMI retry, asynchronous reset, and (with MAPPER_ACK_TIMEOUT_EN)
// the ack timeout with ACK_TIMEOUT=40.
// -----------------------------------------------------------------------------
module tb_mapper_trap_sched;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       at_isr_end = 1'b0;
    logic       trap_req = 1'b0;
    logic [3:0] trap_cause = 4'h0;
    logic       nmi_n;
    logic       map_en;
    logic       trap_busy;
    logic [3:0] cause_q;
    logic       ack_err;

    int checks = 0;
    int failures = 0;

    mapper_trap_sched_if bus_if ();

    mapper_trap_sched #(
        .NMI_HOLD     (16),
        .EXIT_FETCHES (1),
        .ACK_TIMEOUT  (40)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus_if),
        .at_isr_end (at_isr_end),
        .trap_req   (trap_req),
        .trap_cause (trap_cause),
        .nmi_n      (nmi_n),
        .map_en     (map_en),
        .trap_busy  (trap_busy),
        .cause_q    (cause_q),
        .ack_err    (ack_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One opcode fetch. Returns 1 ns after the edge on which the FSM has acted
    // on the resulting m1_rise pulse. Optionally pulses trap_req (cause A) so
    // that it is sampled on that same edge.
    task automatic fetch(input logic [15:0] a, input logic [7:0] op,
                         input logic isr, input logic trap_at_rise);
        @(negedge clk);
        bus_if.addr   = a;
        bus_if.data   = op;
        at_isr_end    = isr;
        bus_if.m1_n   = 1'b0;
        bus_if.mreq_n = 1'b0;
        bus_if.rd_n   = 1'b0;
        repeat (3) @(negedge clk);
        bus_if.m1_n   = 1'b1;
        bus_if.mreq_n = 1'b1;
        bus_if.rd_n   = 1'b1;
        @(posedge clk);
        @(posedge clk);
        if (trap_at_rise) begin
            @(negedge clk);
            trap_req   = 1'b1;
            trap_cause = 4'hA;
        end
        @(posedge clk);
        #1;
        trap_req = 1'b0;
    endtask

    task automatic pulse_trap(input logic [3:0] c);
        @(negedge clk);
        trap_req   = 1'b1;
        trap_cause = c;
        @(negedge clk);
        trap_req   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int low_len;
        int err_at;

        bus_if.m1_n   = 1'b1;
        bus_if.mreq_n = 1'b1;
        bus_if.rd_n   = 1'b1;
        bus_if.addr   = 16'h0000;
        bus_if.data   = 8'h00;
        repeat (3) @(negedge clk);

        // Reset values.
        check("rst_nmi_n", nmi_n, 1);
        check("rst_map_en", map_en, 1);
        check("rst_trap_busy", trap_busy, 0);
        check("rst_cause_q", cause_q, 0);
        check("rst_ack_err", ack_err, 0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // Plain trap, boundary immediately, then vector fetch.
        pulse_trap(4'h3);
        check("armed_busy", trap_busy, 1);
        check("armed_nmi_n", nmi_n, 1);
        check("armed_cause", cause_q, 4'h3);
        fetch(16'h1000, 8'h00, 1'b1, 1'b0);
        check("plain_nmi_low", nmi_n, 0);
        check("plain_map_on", map_en, 1);
        fetch(16'h0066, 8'hF5, 1'b0, 1'b0);
        check("vec_nmi_n", nmi_n, 1);
        check("vec_map_en", map_en, 0);
        check("vec_cause", cause_q, 4'h3);
        check("vec_busy", trap_busy, 1);

        // RETI and a lone 0x45 must not leave supervisor mode.
        fetch(16'h0067, 8'hED, 1'b1, 1'b0);
        fetch(16'h0068, 8'h4D, 1'b1, 1'b0);
        check("reti_stays", map_en, 0);
        fetch(16'h0069, 8'h45, 1'b1, 1'b0);
        check("lone45_stays", map_en, 0);

        // RETN, then one more fetch restores user mode.
        fetch(16'h006A, 8'hED, 1'b1, 1'b0);
        fetch(16'h006B, 8'h45, 1'b1, 1'b0);
        check("retn_map_off", map_en, 0);
        check("retn_busy", trap_busy, 1);
        fetch(16'h1001, 8'h00, 1'b1, 1'b0);
        check("exit_map_on", map_en, 1);
        check("exit_busy", trap_busy, 0);

        // Prefix deferral; a second trap while ARMED is ignored.
        pulse_trap(4'h5);
        pulse_trap(4'h9);
        check("no_queue_cause", cause_q, 4'h5);
        fetch(16'h2000, 8'hDD, 1'b0, 1'b0);
        check("prefix_nmi_n", nmi_n, 1);
        fetch(16'h2001, 8'h21, 1'b1, 1'b0);
        check("boundary_nmi_low", nmi_n, 0);
        check("boundary_cause", cause_q, 4'h5);

        // NMI retry: low for NMI_HOLD clocks, high for one, low again.
        low_len = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (nmi_n) begin
                low_len = i;
                break;
            end
        end
        check("retry_low_len", low_len, 16);
        @(posedge clk);
        #1;
        check("retry_reassert", nmi_n, 0);

        // Asynchronous reset mid-NMI, checked between clock edges.
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_nmi_n", nmi_n, 1);
        check("async_rst_map_en", map_en, 1);
        check("async_rst_busy", trap_busy, 0);
        check("async_rst_cause", cause_q, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // trap_req coincident with m1_rise: ARMED only, no NMI yet.
        fetch(16'h3000, 8'h00, 1'b1, 1'b1);
        check("coincident_nmi_n", nmi_n, 1);
        check("coincident_busy", trap_busy, 1);
        check("coincident_cause", cause_q, 4'hA);
        fetch(16'h3001, 8'h00, 1'b1, 1'b0);
        check("coincident_next_nmi", nmi_n, 0);

`ifdef MAPPER_ACK_TIMEOUT_EN
        // No vector fetch: abandoned 40 clocks after NMI assertion.
        err_at = -1;
        for (int i = 1; i <= 80; i++) begin
            @(posedge clk);
            #1;
            if (ack_err) begin
                err_at = i;
                break;
            end
        end
        check("timeout_clock", err_at, 40);
        check("timeout_map_en", map_en, 1);
        check("timeout_nmi_n", nmi_n, 1);
        check("timeout_busy", trap_busy, 0);
        repeat (5) @(negedge clk);
        check("timeout_sticky", ack_err, 1);
`else
        err_at = 0;
        fetch(16'h0066, 8'hF5, 1'b0, 1'b0);
        check("final_vec_map_off", map_en, 0);
        check("final_ack_err", ack_err, err_at);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mapper_trap_sched.md
Name: mapper_trap_sched

Overview:
- Sequences the mapper's switch between user mode (mapping on) and supervisor mode (mapping off, monitor owns the bus).
- Latches trap requests from the I/O-trap decode and defers them to the next real instruction boundary, as reported by the opcode-boundary tracker. This keeps prefixed opcodes (CB/ED/DD/FD) from being split.
- At the boundary, fires NMI, confirms the 0x0066 vector fetch, and enters supervisor mode.
- Restores user mode a fixed number of M1 fetches after RETN.

Parameters:
- NMI_HOLD, 16: maximum clocks nmi_n is held low per attempt.
- EXIT_FETCHES, 1: M1 fetches after the RETN opcode completes before mapping re-enables.
- ACK_TIMEOUT, 255: clocks allowed from NMI assertion to vector fetch (optional feature only).

Ports:
- clk  in  1  system clock (Z80 clock domain, rising edge)
- reset_n  in  1  asynchronous, active-low reset
- m1_n  in  1  Z80 M1, raw; synchronised internally (2-flop)
- mreq_n  in  1  Z80 MREQ, raw; 2-flop sync
- rd_n  in  1  Z80 RD, raw; 2-flop sync
- addr  in  16  Z80 address bus
- data  in  8  Z80 data bus
- at_isr_end  in  1  instruction-boundary flag from tracker; valid at synchronised M1 rising edge
- trap_req  in  1  one-clock pulse from I/O-trap decode
- trap_cause  in  4  cause code, valid with trap_req
- nmi_n  out  1  NMI to CPU, active low
- map_en  out  1  1 = user mapping active
- trap_busy  out  1  high in any state other than USER
- cause_q  out  4  latched cause of the current trap
- ack_err  out  1  sticky vector-ack timeout flag (optional feature)

Behaviour:
- Reset values: nmi_n=1, map_en=1, trap_busy=0, cause_q=0, ack_err=0. State=USER; internal opcode latch=0x00; all counters=0.
- Reset is asynchronous and active-low; one clock, clk. Reset asserted mid-sequence returns to USER immediately, with nmi_n released in the same instant.
- Sync and edge detection:
  - m1_rise is a 1-clock pulse on a synchronised 0->1 edge of m1_n.
  - Opcode latch captures data every clock while m1_n, mreq_n and rd_n (all synchronised) are 0. It therefore holds the fetched opcode at m1_rise.
  - fetch_addr is latched the same way from addr.
- FSM (all transitions on clk):
  - USER: trap_req -> ARMED; cause_q <= trap_cause.
  - ARMED: m1_rise and at_isr_end=1 -> NMI. m1_rise with at_isr_end=0 stays in ARMED (prefix in flight).
  - NMI: nmi_n=0. Exit on m1_rise with fetch_addr==0x0066 -> SUPER, nmi_n=1. If NMI_HOLD clocks elapse first, nmi_n=1 for one clock, then reassert (stay in NMI, counter reloads).
  - SUPER: map_en=0. On m1_rise, opcode 0xED sets an internal ed_seen flag; any other m1_rise clears it. m1_rise with opcode 0x45 and ed_seen=1 (RETN) -> EXIT, exit counter=EXIT_FETCHES.
  - EXIT: map_en=0. Each m1_rise decrements the counter; at 0 -> USER with map_en=1 in the same clock.
- trap_req outside USER is ignored; cause_q is not overwritten, so there is no queueing.
- trap_req and m1_rise in the same clock in USER: go to ARMED only. The boundary is evaluated on the next m1_rise.
- EXIT_FETCHES=0 is illegal; treat it as 1.
- trap_busy is a registered copy of (state != USER).

Optional Feature:
- Macro: MAPPER_ACK_TIMEOUT_EN.
- With it: a counter runs in NMI from entry. On reaching ACK_TIMEOUT without a vector fetch:
  - nmi_n=1
  - ack_err <= 1 (sticky until reset)
  - state -> USER, map_en=1
- Without it: NMI retries forever, and ack_err is tied 0.

Decomposition:
- Shared package:
  - state encoding (USER, ARMED, NMI, SUPER, EXIT; 3-bit)
  - constants NMI_VECTOR=16'h0066, OP_ED=8'hED, OP_RETN=8'h45
  - cause-code width (4)
- One natural sub-module: z80_bus_sync. It holds the 2-flop sync of m1_n/mreq_n/rd_n, the m1_rise pulse, and the opcode/address fetch latch. The same block is reusable by other bus-watching logic.

Test Plan:
- Plain trap: trap_req (cause 4'h3) -> fetch 0x00 with at_isr_end=1 -> nmi_n low within 1 clock of m1_rise. Then fetch 0x0066 -> nmi_n=1, map_en=0, cause_q=3.
- Prefix deferral: trap_req, then fetch 0xDD (at_isr_end=0) and 0x21 (at_isr_end=1) -> nmi_n stays 1 through the first m1_rise and asserts only after the second.
- RETN exit: in SUPER, fetch 0xED then 0x45, EXIT_FETCHES=1, one more fetch -> map_en=1 and trap_busy=0 one clock after that m1_rise. Fetch 0xED then 0x4D (RETI) -> stays in SUPER.
- NMI retry: no 0x0066 fetch for NMI_HOLD=16 clocks -> nmi_n high for exactly 1 clock, then low again.
- Reset mid-NMI: reset_n=0 while nmi_n=0 -> nmi_n=1 and map_en=1 without waiting for a clock. A second trap_req while ARMED -> cause_q unchanged.
- MAPPER_ACK_TIMEOUT_EN with ACK_TIMEOUT=40: no vector fetch -> at clock 40, ack_err=1, state USER, map_en=1.
